// File: rtl/ram_ctrl_pkg.sv
// Shared definitions for the display RAM access controller.
//   DEF_ADDR_W / DEF_DATA_W : default RAM geometry (256 x 16)
//   state_e                 : sequencer FSM encoding
package ram_ctrl_pkg;

  localparam int unsigned DEF_ADDR_W = 8;
  localparam int unsigned DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StWrite  = 2'd1,
    StSettle = 2'd2,
    StVerify = 2'd3
  } state_e;

endpackage

// File: rtl/ram_access_ctrl_if.sv
// RAM port bundle between the access controller and the 256x16 RAM.
//   ram_addr : word address (controller -> RAM)
//   ram_we   : write enable (controller -> RAM)
//   ram_din  : write data   (controller -> RAM)
//   ram_dout : read data, synchronous with 1-cycle latency (RAM -> controller)
// Modports: master = controller side, slave = RAM side.
interface ram_access_ctrl_if
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W
);

  logic [ADDR_W-1:0] ram_addr;
  logic              ram_we;
  logic [DATA_W-1:0] ram_din;
  logic [DATA_W-1:0] ram_dout;

  modport master (
    output ram_addr,
    output ram_we,
    output ram_din,
    input  ram_dout
  );

  modport slave (
    input  ram_addr,
    input  ram_we,
    input  ram_din,
    output ram_dout
  );

endinterface

// File: rtl/dwell_timer.sv
// Auto-scan dwell timer. Counts tick pulses while auto_en is high and emits a
// one-cycle adv pulse (registered, the cycle after the terminal tick) every
// DWELL ticks.
//   clock, reset : system clock, synchronous active-high reset
//   tick         : timebase enable pulse
//   auto_en      : level enable; low holds the count at zero
//   step_clr     : an accepted manual step restarts the dwell period
//   adv          : auto-advance request pulse
module dwell_timer #(
  parameter int unsigned DWELL = 250
) (
  input  logic clock,
  input  logic reset,
  input  logic tick,
  input  logic auto_en,
  input  logic step_clr,
  output logic adv
);

  localparam int unsigned CNT_W = (DWELL > 1) ? $clog2(DWELL) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DWELL - 1);

  logic [CNT_W-1:0] count_q, count_d;
  logic             adv_q, adv_d;

  always_comb begin
    count_d = count_q;
    adv_d   = 1'b0;
    if (!auto_en || step_clr) begin
      // A step clear wins over a coincident terminal tick: no advance.
      count_d = '0;
    end else if (tick) begin
      if (count_q == LAST) begin
        count_d = '0;
        adv_d   = 1'b1;
      end else begin
        count_d = count_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      count_q <= '0;
      adv_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      adv_q   <= adv_d;
    end
  end

  assign adv = adv_q;

endmodule

// File: rtl/ram_access_ctrl.sv
// Sequencer/arbiter for the display RAM. Serializes write, step and auto-scan
// requests onto the RAM port, verifies each write by read-back and keeps a
// stable registered read word for the display.
//   clock, reset : system clock, synchronous active-high reset
//   tick         : 500 Hz enable for the dwell timer
//   step_req     : pulse, increment address
//   wr_req       : pulse, write wr_data at current address
//   auto_en      : level, enable auto-scan
//   wr_data      : write word, captured when the write is accepted or latched
//   ram          : RAM port bundle (master side)
//   rd_data      : registered read word
//   busy         : FSM outside IDLE
//   wr_done      : pulse during the verify cycle of a write
//   wr_err       : sticky read-back mismatch flag
module ram_access_ctrl
  import ram_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = DEF_ADDR_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned DWELL  = 250
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  step_req,
  input  logic                  wr_req,
  input  logic                  auto_en,
  input  logic [DATA_W-1:0]     wr_data,
  ram_access_ctrl_if.master     ram,
  output logic [DATA_W-1:0]     rd_data,
  output logic                  busy,
  output logic                  wr_done,
  output logic                  wr_err
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic              wr_pend_q, wr_pend_d;
  logic [DATA_W-1:0] wr_pend_data_q, wr_pend_data_d;
  logic              step_pend_q, step_pend_d;
  logic [DATA_W-1:0] rd_data_q;
  logic              ram_we_q;
  logic              wr_done_q;
  logic              wr_err_q;

  logic want_wr, want_step, step_take, adv;

  dwell_timer #(
    .DWELL (DWELL)
  ) u_dwell_timer (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .auto_en  (auto_en),
    .step_clr (step_take),
    .adv      (adv)
  );

  assign want_wr   = wr_req | wr_pend_q;
  assign want_step = step_req | step_pend_q;

  always_comb begin
    state_d        = state_q;
    addr_d         = addr_q;
    wdata_d        = wdata_q;
    wr_pend_d      = wr_pend_q;
    wr_pend_data_d = wr_pend_data_q;
    step_pend_d    = step_pend_q;
    step_take      = 1'b0;

    unique case (state_q)
      StIdle: begin
        // Priority: write > step > auto advance; one action per cycle.
        if (want_wr) begin
          state_d   = StWrite;
          wdata_d   = wr_pend_q ? wr_pend_data_q : wr_data;
          wr_pend_d = 1'b0;
          // Losing step (new or already pending) stays pending.
          if (want_step) begin
            step_pend_d = 1'b1;
          end
        end else if (want_step) begin
          addr_d      = addr_q + ADDR_W'(1);
          step_pend_d = 1'b0;
          step_take   = 1'b1;
        end else if (adv) begin
          addr_d = addr_q + ADDR_W'(1);
        end
      end
      StWrite:  state_d = StSettle;
      StSettle: state_d = StVerify;
      StVerify: state_d = StIdle;
      default:  state_d = StIdle;
    endcase

    // Requests while busy latch one deep; repeats of a set flag are dropped.
    if (state_q != StIdle) begin
      if (wr_req && !wr_pend_q) begin
        wr_pend_d      = 1'b1;
        wr_pend_data_d = wr_data;
      end
      if (step_req) begin
        step_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= StIdle;
      addr_q         <= '0;
      wdata_q        <= '0;
      wr_pend_q      <= 1'b0;
      wr_pend_data_q <= '0;
      step_pend_q    <= 1'b0;
      rd_data_q      <= '0;
      ram_we_q       <= 1'b0;
      wr_done_q      <= 1'b0;
      wr_err_q       <= 1'b0;
    end else begin
      state_q        <= state_d;
      addr_q         <= addr_d;
      wdata_q        <= wdata_d;
      wr_pend_q      <= wr_pend_d;
      wr_pend_data_q <= wr_pend_data_d;
      step_pend_q    <= step_pend_d;
      // Registered so the strobes line up with the WRITE/VERIFY states.
      ram_we_q       <= (state_d == StWrite);
      wr_done_q      <= (state_d == StVerify);
      if (state_q == StIdle || state_q == StVerify) begin
        rd_data_q <= ram.ram_dout;
      end
      if (state_q == StVerify && ram.ram_dout != wdata_q) begin
        wr_err_q <= 1'b1;
      end
    end
  end

  assign ram.ram_addr = addr_q;
  assign ram.ram_we   = ram_we_q;
  assign ram.ram_din  = wdata_q;
  assign rd_data      = rd_data_q;
  assign busy         = (state_q != StIdle);
  assign wr_done      = wr_done_q;
  assign wr_err       = wr_err_q;

endmodule

// File: tb/tb_ram_access_ctrl.sv
// Self-checking bench for ram_access_ctrl with a behavioural RAM and a
// request-level reference model.
module tb_ram_access_ctrl;

  localparam int unsigned DWELL = 4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        tick = 1'b0;
  logic        step_req = 1'b0;
  logic        wr_req = 1'b0;
  logic        auto_en = 1'b0;
  logic [15:0] wr_data = '0;
  logic [15:0] rd_data;
  logic        busy, wr_done, wr_err;

  int vectors = 0;
  int miscompares = 0;

  ram_access_ctrl_if #(.ADDR_W(8), .DATA_W(16)) ram_bus ();

  ram_access_ctrl #(
    .ADDR_W (8),
    .DATA_W (16),
    .DWELL  (DWELL)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .tick     (tick),
    .step_req (step_req),
    .wr_req   (wr_req),
    .auto_en  (auto_en),
    .wr_data  (wr_data),
    .ram      (ram_bus),
    .rd_data  (rd_data),
    .busy     (busy),
    .wr_done  (wr_done),
    .wr_err   (wr_err)
  );

  always #5 clock = ~clock;

  // RAM: synchronous read-first, optional bit-0 corruption on write.
  logic [15:0] mem [256];
  bit          mem_ready = 1'b0;
  bit          corrupt = 1'b0;

  always @(posedge clock) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'((i * 37) ^ 16'h5A00);
      mem_ready <= 1'b1;
    end else if (ram_bus.ram_we) begin
      mem[ram_bus.ram_addr] <= corrupt ? (ram_bus.ram_din ^ 16'h0001) : ram_bus.ram_din;
    end
    ram_bus.ram_dout <= mem[ram_bus.ram_addr];
  end

  // Reference model: busy is a countdown of remaining cycles of a write
  // transaction (3 = write strobe, 1 = verify), requests are flags.
  logic [7:0]  m_addr;
  int          m_left;
  logic [15:0] m_wdata, m_wpd, m_rd;
  bit          m_wp, m_sp, m_err, m_adv;
  int          m_cnt;

  task automatic model_step();
    bit want_w, want_s, stepped, new_adv;
    if (reset) begin
      m_addr = '0; m_left = 0; m_wdata = '0; m_wpd = '0; m_rd = '0;
      m_wp = 0; m_sp = 0; m_err = 0; m_adv = 0; m_cnt = 0;
      return;
    end
    stepped = 0;
    if (m_left == 1 && ram_bus.ram_dout != m_wdata) m_err = 1;
    if (m_left == 0 || m_left == 1) m_rd = ram_bus.ram_dout;
    if (m_left == 0) begin
      want_w = wr_req || m_wp;
      want_s = step_req || m_sp;
      if (want_w) begin
        m_wdata = m_wp ? m_wpd : wr_data;
        m_wp = 0;
        m_left = 3;
        if (want_s) m_sp = 1;
      end else if (want_s) begin
        m_addr = m_addr + 8'd1;
        m_sp = 0;
        stepped = 1;
      end else if (m_adv) begin
        m_addr = m_addr + 8'd1;
      end
    end else begin
      m_left = m_left - 1;
      if (wr_req && !m_wp) begin
        m_wp = 1;
        m_wpd = wr_data;
      end
      if (step_req) m_sp = 1;
    end
    new_adv = 0;
    if (!auto_en || stepped) m_cnt = 0;
    else if (tick) begin
      if (m_cnt == DWELL - 1) begin
        m_cnt = 0;
        new_adv = 1;
      end else m_cnt = m_cnt + 1;
    end
    m_adv = new_adv;
  endtask

  initial begin
    forever begin
      @(posedge clock);
      model_step();
    end
  end

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    vectors++; if (ram_bus.ram_addr !== 8'h00) begin miscompares++;
      $display("FAIL reset_addr got %h want 00", ram_bus.ram_addr); end
    vectors++; if (ram_bus.ram_we !== 1'b0) begin miscompares++;
      $display("FAIL reset_we got %b want 0", ram_bus.ram_we); end
    vectors++; if (ram_bus.ram_din !== 16'h0000) begin miscompares++;
      $display("FAIL reset_din got %h want 0000", ram_bus.ram_din); end
    vectors++; if ({rd_data, busy, wr_done, wr_err} !== 19'h0) begin miscompares++;
      $display("FAIL reset_status got rd=%h busy=%b done=%b err=%b want all 0",
               rd_data, busy, wr_done, wr_err); end
    reset = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_steps();
    for (int k = 1; k <= 3; k++) begin
      step_req = 1'b1;
      @(negedge clock);
      step_req = 1'b0;
      vectors++; if (ram_bus.ram_addr !== 8'(k) || busy !== 1'b0) begin miscompares++;
        $display("FAIL step_addr got %h busy=%b want %h busy=0", ram_bus.ram_addr, busy, 8'(k)); end
      @(negedge clock);
      vectors++; if (rd_data !== mem[k-1]) begin miscompares++;
        $display("FAIL step_rd_early got %h want %h", rd_data, mem[k-1]); end
      @(negedge clock);
      vectors++; if (rd_data !== mem[k] || busy !== 1'b0) begin miscompares++;
        $display("FAIL step_rd got %h busy=%b want %h busy=0", rd_data, busy, mem[k]); end
      repeat (2) @(negedge clock);
    end
  endtask

  task automatic test_wrap();
    step_req = 1'b1;
    repeat (252) @(negedge clock);
    step_req = 1'b0;
    vectors++; if (ram_bus.ram_addr !== 8'hFF) begin miscompares++;
      $display("FAIL wrap_pre got %h want ff", ram_bus.ram_addr); end
    step_req = 1'b1;
    @(negedge clock);
    step_req = 1'b0;
    vectors++; if (ram_bus.ram_addr !== 8'h00) begin miscompares++;
      $display("FAIL wrap got %h want 00", ram_bus.ram_addr); end
  endtask

  task automatic test_write();
    step_req = 1'b1;
    repeat (16) @(negedge clock);
    step_req = 1'b0;
    repeat (2) @(negedge clock);
    wr_req = 1'b1; wr_data = 16'hFF5A;
    @(negedge clock);
    wr_req = 1'b0; wr_data = 16'($urandom);
    vectors++; if ({ram_bus.ram_we, ram_bus.ram_addr, ram_bus.ram_din, busy, wr_done}
                   !== {1'b1, 8'h10, 16'hFF5A, 1'b1, 1'b0}) begin miscompares++;
      $display("FAIL wr_c1 got we=%b a=%h d=%h busy=%b done=%b want 1 10 ff5a 1 0",
               ram_bus.ram_we, ram_bus.ram_addr, ram_bus.ram_din, busy, wr_done); end
    @(negedge clock);
    vectors++; if ({ram_bus.ram_we, busy, wr_done} !== 3'b010) begin miscompares++;
      $display("FAIL wr_c2 got we=%b busy=%b done=%b want 0 1 0", ram_bus.ram_we, busy, wr_done); end
    @(negedge clock);
    vectors++; if ({ram_bus.ram_we, busy, wr_done} !== 3'b011) begin miscompares++;
      $display("FAIL wr_c3 got we=%b busy=%b done=%b want 0 1 1", ram_bus.ram_we, busy, wr_done); end
    @(negedge clock);
    vectors++; if ({rd_data, busy, wr_done, wr_err, ram_bus.ram_addr}
                   !== {16'hFF5A, 3'b000, 8'h10}) begin miscompares++;
      $display("FAIL wr_c4 got rd=%h busy=%b done=%b err=%b a=%h want ff5a 0 0 0 10",
               rd_data, busy, wr_done, wr_err, ram_bus.ram_addr); end
  endtask

  task automatic test_back_to_back();
    wr_req = 1'b1; step_req = 1'b1; wr_data = 16'h1234;
    @(negedge clock);
    wr_req = 1'b0; wr_data = 16'h0BAD;  // step_req stays high: duplicate while busy
    vectors++; if ({ram_bus.ram_we, ram_bus.ram_addr} !== {1'b1, 8'h10}) begin miscompares++;
      $display("FAIL b2b_we got we=%b a=%h want 1 10", ram_bus.ram_we, ram_bus.ram_addr); end
    @(negedge clock);
    step_req = 1'b0;
    repeat (2) @(negedge clock);
    vectors++; if ({busy, ram_bus.ram_addr, rd_data} !== {1'b0, 8'h10, 16'h1234}) begin
      miscompares++;
      $display("FAIL b2b_idle got busy=%b a=%h rd=%h want 0 10 1234", busy, ram_bus.ram_addr,
               rd_data); end
    @(negedge clock);
    vectors++; if (ram_bus.ram_addr !== 8'h11) begin miscompares++;
      $display("FAIL b2b_step got %h want 11", ram_bus.ram_addr); end
    repeat (4) @(negedge clock);
    vectors++; if (ram_bus.ram_addr !== 8'h11 || mem[8'h10] !== 16'h1234) begin miscompares++;
      $display("FAIL b2b_drop got a=%h mem10=%h want 11 1234", ram_bus.ram_addr, mem[8'h10]); end
  endtask

  task automatic test_auto();
    int n;
    auto_en = 1'b1;
    for (int t = 0; t < 80; t++) begin
      tick = (t % 10 == 0);
      @(negedge clock);
      tick = 1'b0;
      n = (t >= 1) ? ((t - 1) / 10 + 1) : 0;  // ticks sampled before this cycle
      if (t % 10 <= 1) begin
        vectors++; if (ram_bus.ram_addr !== 8'(8'h11 + n / 4)) begin miscompares++;
          $display("FAIL auto t=%0d got %h want %h", t, ram_bus.ram_addr, 8'(8'h11 + n / 4)); end
      end
    end
    for (int t = 0; t < 30; t++) begin
      tick = (t % 10 == 0);
      @(negedge clock);
      tick = 1'b0;
    end
    auto_en = 1'b0;
    repeat (2) @(negedge clock);
    auto_en = 1'b1;
    for (int t = 0; t < 35; t++) begin
      tick = (t % 10 == 0);
      @(negedge clock);
      tick = 1'b0;
      if (t == 29) begin
        vectors++; if (ram_bus.ram_addr !== 8'h13) begin miscompares++;
          $display("FAIL auto_restart got %h want 13", ram_bus.ram_addr); end
      end
      if (t == 34) begin
        vectors++; if (ram_bus.ram_addr !== 8'h14) begin miscompares++;
          $display("FAIL auto_after got %h want 14", ram_bus.ram_addr); end
      end
    end
    auto_en = 1'b0;
    @(negedge clock);
  endtask

  task automatic test_err_and_reset();
    corrupt = 1'b1;
    wr_req = 1'b1; wr_data = 16'hC3C3;
    @(negedge clock);
    wr_req = 1'b0;
    repeat (2) @(negedge clock);
    vectors++; if (wr_err !== 1'b0 || wr_done !== 1'b1) begin miscompares++;
      $display("FAIL err_verify got err=%b done=%b want 0 1", wr_err, wr_done); end
    @(negedge clock);
    vectors++; if (wr_err !== 1'b1 || rd_data !== 16'hC3C2) begin miscompares++;
      $display("FAIL err_set got err=%b rd=%h want 1 c3c2", wr_err, rd_data); end
    corrupt = 1'b0;
    wr_req = 1'b1; wr_data = 16'h0F0E;
    @(negedge clock);
    wr_req = 1'b0;
    repeat (4) @(negedge clock);
    vectors++; if (wr_err !== 1'b1 || rd_data !== 16'h0F0E) begin miscompares++;
      $display("FAIL err_sticky got err=%b rd=%h want 1 0f0e", wr_err, rd_data); end
    wr_req = 1'b1; wr_data = 16'h7777;
    @(negedge clock);
    wr_req = 1'b0;
    vectors++; if (ram_bus.ram_we !== 1'b1) begin miscompares++;
      $display("FAIL rst_pre_we got %b want 1", ram_bus.ram_we); end
    reset = 1'b1;
    @(negedge clock);
    vectors++; if ({ram_bus.ram_we, ram_bus.ram_addr, ram_bus.ram_din, rd_data, busy, wr_done,
                    wr_err} !== 44'h0) begin miscompares++;
      $display("FAIL rst_mid got we=%b a=%h d=%h rd=%h busy=%b done=%b err=%b want all 0",
               ram_bus.ram_we, ram_bus.ram_addr, ram_bus.ram_din, rd_data, busy, wr_done,
               wr_err); end
    reset = 1'b0;
    repeat (6) @(negedge clock);
    vectors++; if ({busy, ram_bus.ram_addr} !== 9'h0) begin miscompares++;
      $display("FAIL rst_pend got busy=%b a=%h want 0 00", busy, ram_bus.ram_addr); end
  endtask

  task automatic test_random();
    logic [43:0] got, want;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      got  = {ram_bus.ram_addr, ram_bus.ram_we, ram_bus.ram_din, rd_data, busy, wr_done, wr_err};
      want = {m_addr, (m_left == 3), m_wdata, m_rd, (m_left != 0), (m_left == 1), m_err};
      vectors++; if (got !== want) begin miscompares++;
        $display("FAIL random c=%0d got %h want %h", c, got, want); end
      wr_req   = ($urandom_range(99) < 15);
      step_req = ($urandom_range(99) < 20);
      tick     = ($urandom_range(99) < 30);
      wr_data  = 16'($urandom);
      reset    = ($urandom_range(199) == 0);
      if ($urandom_range(99) == 0) auto_en = ~auto_en;
      if ($urandom_range(299) == 0) corrupt = ~corrupt;
    end
    @(negedge clock);
    {wr_req, step_req, tick, reset, auto_en, corrupt} = '0;
  endtask

  initial begin
    test_reset();
    test_steps();
    test_wrap();
    test_write();
    test_back_to_back();
    test_auto();
    test_err_and_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ram_access_ctrl.md
# ram_access_ctrl

Sequencer and arbiter for the 256×16 RAM in the display controller. It takes debounced step and write pulses plus an optional auto-scan timebase, and it serializes them into RAM address, write-enable and data. It also verifies every write by read-back and presents a stable read word to the display muxes. It replaces the free-running address sequencer and the direct write-pulse path, and sits between the debouncers and the RAM.

## Interface
Parameters:
- ADDR_W, 8: RAM address width.
- DATA_W, 16: RAM word width.
- DWELL, 250: number of `tick` pulses between auto-scan advances; minimum 1.

Ports:
- clock, in, 1: system clock. One clock only.
- reset, in, 1: synchronous, active-high reset.
- tick, in, 1: one-cycle enable at 500 Hz; drives the dwell timer.
- step_req, in, 1: one-cycle pulse requesting an address increment.
- wr_req, in, 1: one-cycle pulse requesting a write of `wr_data` at the current address.
- auto_en, in, 1: level input; enables auto-scan.
- wr_data, in, DATA_W: write word, sampled on the cycle `wr_req` is accepted or latched.
- ram_dout, in, DATA_W: RAM read port. Synchronous read with 1-cycle latency.
- ram_addr, out, ADDR_W: RAM address.
- ram_we, out, 1: RAM write enable.
- ram_din, out, DATA_W: RAM write data.
- rd_data, out, DATA_W: registered read word for the display.
- busy, out, 1: high when the FSM is not in IDLE.
- wr_done, out, 1: one-cycle pulse when a write's verification completes.
- wr_err, out, 1: sticky flag; set on read-back mismatch.

## Operation
- FSM states: IDLE, WRITE, SETTLE, VERIFY.
- IDLE:
  - A pending or new write takes priority over a step, and a step takes priority over an auto advance. At most one action is taken per cycle.
  - On a write, capture `wr_data` into the `wdata` register, then go to WRITE.
  - On a step or auto advance, `ram_addr <= ram_addr + 1`. The address wraps 255→0. Stay in IDLE.
- WRITE: `ram_we=1` and `ram_din=wdata` for exactly one cycle; `ram_addr` is held. Next state is SETTLE.
- SETTLE: `ram_we=0`; wait one cycle for the read latency. Next state is VERIFY.
- VERIFY:
  - `rd_data <= ram_dout`.
  - If `ram_dout != wdata`, set `wr_err`.
  - Pulse `wr_done`, then return to IDLE.
- rd_data: loads `ram_dout` every cycle in IDLE and VERIFY, and holds in WRITE and SETTLE.
- Pending requests:
  - `step_req` or `wr_req` arriving while busy sets a one-deep pending flag for its type. Further pulses of the same type while that flag is set are dropped.
  - Pending flags are served from IDLE in priority order, one per IDLE cycle.
  - A request arriving in the same IDLE cycle as a pending request of the other type is arbitrated by priority, and the loser is latched.
  - Behaviour for simultaneous `wr_req` and `step_req` in IDLE: the write is taken and the step becomes pending.
- Dwell timer:
  - Counts `tick` pulses while `auto_en=1`.
  - When the count reaches DWELL−1 on a tick, it raises `adv` and resets to 0.
  - Clears when `auto_en=0`, and clears on any accepted step.
  - An `adv` that coincides with busy or with a higher-priority request is dropped, not latched.
- Reset mid-write:
  - `ram_we` drops in the same cycle `reset` is sampled.
  - The FSM returns to IDLE and pending flags clear.
  - The RAM contents are undefined for that address.

## Timing
- Reset values:
  - ram_addr=0, ram_we=0, ram_din=0, rd_data=0.
  - busy=0, wr_done=0, wr_err=0.
  - Dwell count=0; pending flags=0.
- Step latency: `ram_addr` changes on the edge after `step_req` is sampled in IDLE. New data reaches `rd_data` 2 cycles after the address change.
- Write latency, from the `wr_req` edge:
  - ram_we is high in cycle +1.
  - wr_done and the `rd_data` update occur in cycle +3.
  - busy is high in cycles +1..+3.
  - The earliest next action is cycle +4.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package `ram_ctrl_pkg`:
  - ADDR_W and DATA_W defaults.
  - FSM state encoding: IDLE=2'd0, WRITE=2'd1, SETTLE=2'd2, VERIFY=2'd3.
- Sub-module `dwell_timer` contains the tick counter, the `auto_en` clear, the step clear and the `adv` pulse, parameterized by DWELL.
- The top contains the FSM, the arbiter with pending flags, and the address and data registers.

## Test plan
- Reset, then three `step_req` pulses 5 cycles apart: `ram_addr` goes 0→1→2→3, `busy` stays 0 throughout, and `rd_data` follows `ram_dout` 2 cycles after each change.
- From address 0xFF, one `step_req`: `ram_addr` wraps to 0x00.
- `wr_req` with `wr_data`=0xFF5A at address 0x10 on an ideal RAM model:
  - `ram_we` is high for exactly 1 cycle at addr 0x10, din 0xFF5A.
  - `wr_done` pulses at +3, `rd_data`=0xFF5A, `wr_err`=0.
- Simultaneous `wr_req` and `step_req` in IDLE, plus a second `step_req` while busy:
  - The write completes at the original address.
  - Exactly one increment follows on the first IDLE cycle.
  - The duplicate step is dropped.
- `auto_en`=1 with DWELL=4 and `tick` every 10 cycles: the address advances once every 40 cycles. Deassert `auto_en` after 3 ticks and reassert it: the count restarts from 0.
- RAM model that corrupts bit 0 on write: `wr_err` sets at VERIFY and stays set through later clean writes until `reset`. Asserting `reset` during WRITE drops `ram_we` in the same cycle and returns all outputs to their reset values.
